simd_inst_fetch: RTL and testbench



---
 rtl/simd_inst_fetch.sv | 137 +++++++++++++
 tb/tb_simd_inst_fetch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_inst_fetch.sv
// Instruction fetch and in-order commit tracking between the SIMD driver and the ALU.
// Optional build macro: SIMD_INST_PARITY_EN adds an even-parity bit per instruction word.
module simd_inst_fetch #(
  parameter int N_INST    = 16,
  parameter int INST_W    = 32,
  parameter int WBW       = 32,
  parameter int VDIM      = 6,
  parameter int MAX_WARP  = 16,
  parameter int N_PENDING = 4,
  localparam int PC_BW    = $clog2(N_INST + 1),
  localparam int WID_BW   = $clog2(MAX_WARP),
  localparam int OFS_W    = WBW * VDIM
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_we,
  input  logic [PC_BW-1:0]  i_cfg_addr,
  input  logic [INST_W-1:0] i_cfg_inst,
  input  logic              inst_rdy,
  output logic              inst_ack,
  input  logic [PC_BW-1:0]  i_pc,
  input  logic [WID_BW-1:0] i_warpid,
  input  logic [OFS_W-1:0]  i_bofs,
  input  logic [OFS_W-1:0]  i_aofs,
  output logic              alu_rdy,
  input  logic              alu_ack,
  output logic [INST_W-1:0] o_inst,
  output logic [PC_BW-1:0]  o_pc,
  output logic [WID_BW-1:0] o_warpid,
  output logic [OFS_W-1:0]  o_bofs,
  output logic [OFS_W-1:0]  o_aofs,
  input  logic              wb_dval,
  output logic              inst_commit_dval,
  output logic [WID_BW-1:0] o_commit_warpid,
  output logic              o_err
);

  localparam int AW = (N_INST > 1) ? $clog2(N_INST) : 1;
  localparam int PW = (N_PENDING > 1) ? $clog2(N_PENDING) : 1;
  localparam int CW = $clog2(N_PENDING + 1);
  localparam logic [PC_BW-1:0] N_INST_L    = PC_BW'(N_INST);
  localparam logic [CW:0]      N_PENDING_L = (CW + 1)'(N_PENDING);
  localparam logic [PW-1:0]    LAST_PTR    = PW'(N_PENDING - 1);

  logic [INST_W-1:0] mem [N_INST];
`ifdef SIMD_INST_PARITY_EN
  logic              mem_par [N_INST];
`endif

  logic [WID_BW-1:0] fifo_mem [N_PENDING];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;

  logic              busy, cfg_ok, cfg_busy_err;
  logic              pc_ok, parity_bad;
  logic [INST_W-1:0] fetch_word;
  logic              push, pop, underflow;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The output register always holds a reserved FIFO slot, so push can never overflow.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, alu_rdy};
  assign inst_ack  = i_rst_n && inst_rdy && (!alu_rdy || alu_ack) && (occupancy < N_PENDING_L);

  assign busy         = alu_rdy || (count != '0);
  assign cfg_ok       = i_cfg_we && !busy && (i_cfg_addr < N_INST_L);
  assign cfg_busy_err = i_cfg_we && busy;

  assign pc_ok      = (i_pc < N_INST_L);
  assign fetch_word = pc_ok ? mem[i_pc[AW-1:0]] : '0;
`ifdef SIMD_INST_PARITY_EN
  assign parity_bad = pc_ok && ((^fetch_word) != mem_par[i_pc[AW-1:0]]);
`else
  assign parity_bad = 1'b0;
`endif

  assign push      = alu_rdy && alu_ack;
  assign pop       = wb_dval && (count != '0);
  assign underflow = wb_dval && (count == '0);

  // NOTE: storage arrays carry no reset; occupancy/valid state guards every read.
  always_ff @(posedge i_clk) begin
    if (cfg_ok) begin
      mem[i_cfg_addr[AW-1:0]] <= i_cfg_inst;
`ifdef SIMD_INST_PARITY_EN
      mem_par[i_cfg_addr[AW-1:0]] <= ^i_cfg_inst;
`endif
    end
    if (push) fifo_mem[wr_ptr] <= o_warpid;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      alu_rdy          <= 1'b0;
      o_inst           <= '0;
      o_pc             <= '0;
      o_warpid         <= '0;
      o_bofs           <= '0;
      o_aofs           <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      inst_commit_dval <= 1'b0;
      o_commit_warpid  <= '0;
      o_err            <= 1'b0;
    end else begin
      if (inst_ack) begin
        alu_rdy  <= 1'b1;
        o_inst   <= fetch_word;
        o_pc     <= i_pc;
        o_warpid <= i_warpid;
        o_bofs   <= i_bofs;
        o_aofs   <= i_aofs;
      end else if (alu_ack) begin
        alu_rdy <= 1'b0;
      end

      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      inst_commit_dval <= pop;
      if (pop) o_commit_warpid <= fifo_mem[rd_ptr];

      if ((inst_ack && (!pc_ok || parity_bad)) || underflow || cfg_busy_err)
        o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_simd_inst_fetch.sv
// Directed self-checking bench for simd_inst_fetch: fetch, backpressure, commit FIFO, errors, reset.
module tb_simd_inst_fetch;

  localparam int PC_BW  = 5;
  localparam int INST_W = 32;
  localparam int WID_BW = 4;
  localparam int OFS_W  = 192;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_cfg_we;
  logic [PC_BW-1:0]  i_cfg_addr;
  logic [INST_W-1:0] i_cfg_inst;
  logic              inst_rdy, inst_ack;
  logic [PC_BW-1:0]  i_pc;
  logic [WID_BW-1:0] i_warpid;
  logic [OFS_W-1:0]  i_bofs, i_aofs;
  logic              alu_rdy, alu_ack;
  logic [INST_W-1:0] o_inst;
  logic [PC_BW-1:0]  o_pc;
  logic [WID_BW-1:0] o_warpid;
  logic [OFS_W-1:0]  o_bofs, o_aofs;
  logic              wb_dval, inst_commit_dval;
  logic [WID_BW-1:0] o_commit_warpid;
  logic              o_err;

  int n_checks = 0;
  int n_errors = 0;

  simd_inst_fetch dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_inst(i_cfg_inst),
    .inst_rdy(inst_rdy), .inst_ack(inst_ack),
    .i_pc(i_pc), .i_warpid(i_warpid), .i_bofs(i_bofs), .i_aofs(i_aofs),
    .alu_rdy(alu_rdy), .alu_ack(alu_ack),
    .o_inst(o_inst), .o_pc(o_pc), .o_warpid(o_warpid), .o_bofs(o_bofs), .o_aofs(o_aofs),
    .wb_dval(wb_dval), .inst_commit_dval(inst_commit_dval),
    .o_commit_warpid(o_commit_warpid), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [OFS_W-1:0] got, input logic [OFS_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cfg_write(input logic [PC_BW-1:0] addr, input logic [INST_W-1:0] data);
    i_cfg_we   = 1'b1;
    i_cfg_addr = addr;
    i_cfg_inst = data;
    step();
    i_cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_inst = '0;
    inst_rdy = 1'b1; i_pc = 5'd3; i_warpid = '0; alu_ack = 1'b0; wb_dval = 1'b0;
    i_bofs = {6{32'hA5A5_0001}};
    i_aofs = {6{32'h0F0F_0002}};

    // Reset state, with a tuple offered so the forced-low ack is visible.
    step();
    check("rst_ack", inst_ack, 0);
    step();
    check("rst_alu_rdy", alu_rdy, 0);
    check("rst_o_inst", o_inst, 0);
    check("rst_commit", inst_commit_dval, 0);
    check("rst_err", o_err, 0);
    inst_rdy = 1'b0;
    i_rst_n  = 1'b1;
    step();

    // Basic fetch and commit.
    cfg_write(5'd3, 32'hDEAD_BEEF);
    cfg_write(5'd7, 32'h1234_5678);
    inst_rdy = 1'b1; i_pc = 5'd3; i_warpid = 4'd5; alu_ack = 1'b1;
    settle();
    check("basic_ack", inst_ack, 1);
    step();
    inst_rdy = 1'b0;
    check("basic_rdy", alu_rdy, 1);
    check("basic_inst", o_inst, 32'hDEAD_BEEF);
    check("basic_wid", o_warpid, 5);
    check("basic_pc", o_pc, 3);
    check("basic_bofs", o_bofs, {6{32'hA5A5_0001}});
    check("basic_aofs", o_aofs, {6{32'h0F0F_0002}});
    step();
    check("basic_drain", alu_rdy, 0);
    wb_dval = 1'b1;
    step();
    wb_dval = 1'b0;
    check("basic_commit", inst_commit_dval, 1);
    check("basic_commit_wid", o_commit_warpid, 5);
    step();
    check("basic_commit_pulse", inst_commit_dval, 0);

    // Backpressure: ALU stalls, second tuple waits, then loads on release.
    alu_ack = 1'b0; inst_rdy = 1'b1; i_pc = 5'd7; i_warpid = 4'd2;
    settle();
    check("bp_ack0", inst_ack, 1);
    step();
    check("bp_inst0", o_inst, 32'h1234_5678);
    i_pc = 5'd3; i_warpid = 4'd9;
    settle();
    check("bp_stall_ack", inst_ack, 0);
    step();
    check("bp_hold_rdy", alu_rdy, 1);
    check("bp_hold_inst", o_inst, 32'h1234_5678);
    check("bp_hold_wid", o_warpid, 2);
    alu_ack = 1'b1;
    settle();
    check("bp_release_ack", inst_ack, 1);
    step();
    inst_rdy = 1'b0;
    check("bp_next_inst", o_inst, 32'hDEAD_BEEF);
    check("bp_next_wid", o_warpid, 9);
    step();
    wb_dval = 1'b1;
    step();
    check("bp_commit_a", o_commit_warpid, 2);
    step();
    check("bp_commit_b", o_commit_warpid, 9);
    check("bp_commit_b_v", inst_commit_dval, 1);
    wb_dval = 1'b0;
    step();

    // FIFO reservation: four outstanding instructions block the fifth.
    alu_ack = 1'b1; inst_rdy = 1'b1; i_pc = 5'd3;
    for (int i = 0; i < 4; i++) begin
      i_warpid = WID_BW'(i);
      settle();
      check("full_accept", inst_ack, 1);
      step();
    end
    i_warpid = 4'd4;
    settle();
    check("full_block_a", inst_ack, 0);
    step();
    check("full_rdy_low", alu_rdy, 0);
    settle();
    check("full_block_b", inst_ack, 0);
    wb_dval = 1'b1;
    settle();
    check("full_block_c", inst_ack, 0);
    step();
    wb_dval = 1'b0;
    check("full_commit0", o_commit_warpid, 0);
    settle();
    check("full_unblock", inst_ack, 1);
    step();
    inst_rdy = 1'b0;
    check("full_fifth_wid", o_warpid, 4);
    step();
    wb_dval = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("full_commit_seq", o_commit_warpid, WID_BW'(k));
    end
    wb_dval = 1'b0;
    step();
    check("no_err_so_far", o_err, 0);

    // Underflow and out-of-range PC.
    wb_dval = 1'b1;
    step();
    wb_dval = 1'b0;
    check("uf_no_pulse", inst_commit_dval, 0);
    check("uf_err", o_err, 1);
    do_reset();
    check("err_cleared", o_err, 0);
    inst_rdy = 1'b1; i_pc = 5'd16; i_warpid = 4'd1;
    step();
    inst_rdy = 1'b0;
    check("oor_rdy", alu_rdy, 1);
    check("oor_inst", o_inst, 0);
    check("oor_pc", o_pc, 16);
    check("oor_err", o_err, 1);
    step();
    wb_dval = 1'b1;
    step();
    wb_dval = 1'b0;
    check("oor_commit_wid", o_commit_warpid, 1);

    // Config write while two instructions are pending, then reset mid-stream.
    do_reset();
    inst_rdy = 1'b1; i_pc = 5'd7; i_warpid = 4'd6;
    step();
    i_warpid = 4'd7;
    step();
    inst_rdy = 1'b0;
    step();
    cfg_write(5'd3, 32'hCAFE_F00D);
    check("cfg_busy_err", o_err, 1);
    alu_ack = 1'b0; inst_rdy = 1'b1; i_warpid = 4'd8;
    step();
    check("mid_rdy", alu_rdy, 1);
    i_rst_n = 1'b0;
    settle();
    check("mid_rst_ack", inst_ack, 0);
    step();
    i_rst_n = 1'b1; inst_rdy = 1'b0;
    check("mid_rst_rdy", alu_rdy, 0);
    check("mid_rst_err", o_err, 0);
    wb_dval = 1'b1;
    step();
    wb_dval = 1'b0;
    check("mid_fifo_empty", inst_commit_dval, 0);
    check("mid_fifo_uf", o_err, 1);
    do_reset();

    alu_ack = 1'b1; inst_rdy = 1'b1; i_pc = 5'd3; i_warpid = 4'd0;
    step();
    inst_rdy = 1'b0;
    check("mem_kept_3", o_inst, 32'hDEAD_BEEF);
    step();
    wb_dval = 1'b1;
    step();
    wb_dval = 1'b0;

    // Write and fetch of the same address in one cycle returns the old word.
    i_cfg_we = 1'b1; i_cfg_addr = 5'd7; i_cfg_inst = 32'h0BAD_F00D;
    inst_rdy = 1'b1; i_pc = 5'd7; i_warpid = 4'd3;
    step();
    i_cfg_we = 1'b0; inst_rdy = 1'b0;
    check("rw_old_word", o_inst, 32'h1234_5678);
    check("rw_no_err", o_err, 0);
    step();
    wb_dval = 1'b1;
    step();
    wb_dval = 1'b0;
    step();
    inst_rdy = 1'b1;
    step();
    inst_rdy = 1'b0;
    check("rw_new_word", o_inst, 32'h0BAD_F00D);
    step();
    wb_dval = 1'b1;
    step();
    wb_dval = 1'b0;
    step();

`ifdef SIMD_INST_PARITY_EN
    dut.mem_par[3] = ~dut.mem_par[3];
    i_pc = 5'd3; inst_rdy = 1'b1;
    step();
    inst_rdy = 1'b0;
    check("par_inst", o_inst, 32'hDEAD_BEEF);
    check("par_err", o_err, 1);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
